frog_hop_gen: RTL and testbench



---
 rtl/frog_pkg.sv | 38 +++
 rtl/frog_sprite_rom.sv | 64 ++++++
 rtl/frog_hop_gen.sv | 250 +++++++++++++++++++++++++
 tb/tb_frog_hop_gen.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// -----------------------------------------------------------------------------
// frog_pkg
// Shared types and constants for the frog renderer.
//   dir_t    : hop / facing direction (0=up, 1=down, 2=left, 3=right)
//   state_t  : animation FSM states
//   colours  : 6-bit RRGGBB art palette
//   in_box() : inclusive rectangle test on 32x32 art coordinates
// -----------------------------------------------------------------------------
package frog_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOP  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam logic [5:0] LIGHT_GREEN = 6'b001100;
  localparam logic [5:0] ORANGE      = 6'b110100;
  localparam logic [5:0] EYE_WHITE   = 6'b111111;
  localparam logic [5:0] PUPIL       = 6'b000001;
  localparam logic [5:0] SPLAT_RED   = 6'b110000;

  // True when (x,y) lies inside the inclusive box [x0..x1] x [y0..y1].
  function automatic logic in_box(input logic [4:0] x, input logic [4:0] y,
                                  input int x0, input int x1,
                                  input int y0, input int y1);
    return (int'(x) >= x0) && (int'(x) <= x1) &&
           (int'(y) >= y0) && (int'(y) <= y1);
  endfunction

endpackage

// File: rtl/frog_sprite_rom.sv
// -----------------------------------------------------------------------------
// frog_sprite_rom
// Combinational 32x32 frog art lookup, upright orientation.
// Ports:
//   lx, ly  in  5  art coordinates (already oriented and scaled)
//   pose    in  1  1 = legs extended, 0 = legs tucked
//   dead    in  1  1 = draw the splat instead of the frog
//   opaque  out 1  pixel belongs to the art
//   color   out 6  RRGGBB colour, 0 when transparent
// -----------------------------------------------------------------------------
module frog_sprite_rom
  import frog_pkg::*;
(
  input  logic [4:0] lx,
  input  logic [4:0] ly,
  input  logic       pose,
  input  logic       dead,
  output logic       opaque,
  output logic [5:0] color
);

  logic pupil;
  logic eye;
  logic body;
  logic centre;
  logic legs;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves a signal unassigned would infer a latch.
  always_comb begin
    pupil  = in_box(lx, ly, 9, 10, 2, 4) || in_box(lx, ly, 21, 22, 2, 4);
    eye    = in_box(lx, ly, 6, 10, 2, 6) || in_box(lx, ly, 21, 25, 2, 6);
    body   = in_box(lx, ly, 4, 27, 6, 20);
    centre = in_box(lx, ly, 9, 22, 10, 18);
    legs   = pose ? (in_box(lx, ly, 0, 7, 20, 29) || in_box(lx, ly, 24, 31, 20, 29))
                  : (in_box(lx, ly, 2, 7, 20, 25) || in_box(lx, ly, 24, 29, 20, 25));

    opaque = 1'b0;
    color  = '0;
    // Front-most layer first: eyes overlap the top row of the body.
    if (dead) begin
      if (eye) begin
        opaque = 1'b1;
        color  = EYE_WHITE;
      end else if (body || legs) begin
        opaque = 1'b1;
        color  = SPLAT_RED;
      end
    end else if (pupil) begin
      opaque = 1'b1;
      color  = PUPIL;
    end else if (eye) begin
      opaque = 1'b1;
      color  = EYE_WHITE;
    end else if (centre) begin
      opaque = 1'b1;
      color  = ORANGE;
    end else if (body || legs) begin
      opaque = 1'b1;
      color  = LIGHT_GREEN;
    end
  end

endmodule

// File: rtl/frog_hop_gen.sv
// -----------------------------------------------------------------------------
// frog_hop_gen
// Frog position + hop/death animation FSM advanced by frame_tick, and a
// registered sprite renderer for the VGA colour stream.
// Ports:
//   clk, reset          pixel clock, synchronous active-high reset
//   frame_tick          one pulse per frame
//   hop_req, hop_dir    hop request and direction (0 up,1 down,2 left,3 right)
//   kill                collision pulse, enters the splat animation
//   colPos, rowPos      current pixel coordinate
//   frog_x, frog_y      sprite top-left
//   busy, dead          FSM status (HOP or DEAD / DEAD only)
//   in_frog, color      registered pixel result for the previous coordinate
// Build option: define FROG_HOP_QUEUE_EN for a one-entry hop buffer that
// holds a request made during a hop and issues it when the hop completes.
// -----------------------------------------------------------------------------
module frog_hop_gen
  import frog_pkg::*;
#(
  parameter int FROG_SIZE    = 32,
  parameter int STEP         = 32,
  parameter int HOP_FRAMES   = 4,
  parameter int DEATH_FRAMES = 30,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int START_X      = 304,
  parameter int START_Y      = 448
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       hop_req,
  input  logic [1:0] hop_dir,
  input  logic       kill,
  input  logic [9:0] colPos,
  input  logic [9:0] rowPos,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic       busy,
  output logic       dead,
  output logic       in_frog,
  output logic [5:0] color
);

  localparam int CNT_MAX  = (HOP_FRAMES > DEATH_FRAMES) ? HOP_FRAMES : DEATH_FRAMES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int SCALE_SH = $clog2(FROG_SIZE / 32);

  localparam logic [CNT_W-1:0] HOP_LAST   = CNT_W'(HOP_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOP_HALF   = CNT_W'(HOP_FRAMES / 2);
  localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [9:0]       HOP_DELTA  = 10'(STEP / HOP_FRAMES);
  localparam logic [10:0]      STEP_W     = 11'(STEP);
  localparam logic [10:0]      MAX_X_W    = 11'(SCREEN_W - FROG_SIZE);
  localparam logic [10:0]      MAX_Y_W    = 11'(SCREEN_H - FROG_SIZE);
  localparam logic [10:0]      SIZE_W     = 11'(FROG_SIZE);

  state_t           state, state_n;
  dir_t             facing, facing_n;
  dir_t             dir, dir_n;
  logic [CNT_W-1:0] frame_cnt, cnt_n;
  logic [9:0]       x_n, y_n;
  logic [9:0]       step_x, step_y;
  logic             issue;
  dir_t             req_dir;

`ifdef FROG_HOP_QUEUE_EN
  logic q_valid, q_valid_n;
  dir_t q_dir, q_dir_n;
`endif

  // Edge check on the full-hop target, done before moving so nothing wraps.
  function automatic logic hop_ok(input dir_t d, input logic [9:0] x, input logic [9:0] y);
    case (d)
      UP:      return {1'b0, y} >= STEP_W;
      DOWN:    return ({1'b0, y} + STEP_W) <= MAX_Y_W;
      LEFT:    return {1'b0, x} >= STEP_W;
      default: return ({1'b0, x} + STEP_W) <= MAX_X_W;
    endcase
  endfunction

  // Position after one frame of movement in the latched hop direction.
  always_comb begin
    step_x = frog_x;
    step_y = frog_y;
    case (dir)
      UP:      step_y = frog_y - HOP_DELTA;
      DOWN:    step_y = frog_y + HOP_DELTA;
      LEFT:    step_x = frog_x - HOP_DELTA;
      default: step_x = frog_x + HOP_DELTA;
    endcase
  end

  // Next-state logic. Priority: kill > frame_tick > hop_req (reset is in the
  // register process).
  always_comb begin
    state_n  = state;
    facing_n = facing;
    dir_n    = dir;
    cnt_n    = frame_cnt;
    x_n      = frog_x;
    y_n      = frog_y;
    issue    = 1'b0;
    req_dir  = dir_t'(hop_dir);
`ifdef FROG_HOP_QUEUE_EN
    q_valid_n = q_valid;
    q_dir_n   = q_dir;
`endif

    if (kill && state != DEAD) begin
      state_n = DEAD;
      cnt_n   = '0;
`ifdef FROG_HOP_QUEUE_EN
      q_valid_n = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: issue = hop_req;
        HOP: begin
`ifdef FROG_HOP_QUEUE_EN
          if (hop_req) begin
            q_valid_n = 1'b1;
            q_dir_n   = dir_t'(hop_dir);
          end
`endif
          if (frame_tick) begin
            x_n   = step_x;
            y_n   = step_y;
            cnt_n = frame_cnt + CNT_W'(1);
            if (frame_cnt == HOP_LAST) begin
              state_n = IDLE;
`ifdef FROG_HOP_QUEUE_EN
              // Buffered request is evaluated against the landed position.
              issue     = q_valid_n;
              req_dir   = q_dir_n;
              q_valid_n = 1'b0;
`endif
            end
          end
        end
        DEAD: begin
          if (frame_tick) begin
            if (frame_cnt == DEATH_LAST) begin
              state_n  = IDLE;
              cnt_n    = '0;
              x_n      = 10'(START_X);
              y_n      = 10'(START_Y);
              facing_n = UP;
            end else begin
              cnt_n = frame_cnt + CNT_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // A dropped out-of-range request still turns the frog.
    if (issue) begin
      facing_n = req_dir;
      if (hop_ok(req_dir, x_n, y_n)) begin
        state_n = HOP;
        dir_n   = req_dir;
        cnt_n   = '0;
      end
    end
  end

  assign busy = (state != IDLE);
  assign dead = (state == DEAD);

  // Pixel path: hit test, local coordinates, orientation, art lookup.
  logic [10:0] col_end, row_end;
  logic        hit;
  logic [9:0]  lx_full, ly_full;
  logic [4:0]  lx, ly, ax, ay;
  logic        pose;
  logic        rom_opaque;
  logic [5:0]  rom_color;
  logic        pix_on;

  assign col_end = {1'b0, frog_x} + SIZE_W;
  assign row_end = {1'b0, frog_y} + SIZE_W;
  assign hit     = (colPos >= frog_x) && ({1'b0, colPos} < col_end) &&
                   (rowPos >= frog_y) && ({1'b0, rowPos} < row_end);
  assign lx_full = colPos - frog_x;
  assign ly_full = rowPos - frog_y;
  assign lx      = 5'(lx_full >> SCALE_SH);
  assign ly      = 5'(ly_full >> SCALE_SH);
  assign pose    = (state == HOP) && (frame_cnt < HOP_HALF);

  always_comb begin
    ax = lx;
    ay = ly;
    case (facing)
      UP:      begin ax = lx;          ay = ly; end
      DOWN:    begin ax = lx;          ay = 5'd31 - ly; end
      LEFT:    begin ax = ly;          ay = lx; end
      default: begin ax = 5'd31 - ly;  ay = lx; end
    endcase
  end

  frog_sprite_rom u_rom (
    .lx     (ax),
    .ly     (ay),
    .pose   (pose),
    .dead   (dead),
    .opaque (rom_opaque),
    .color  (rom_color)
  );

  assign pix_on = hit && rom_opaque;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      facing    <= UP;
      dir       <= UP;
      frame_cnt <= '0;
      frog_x    <= 10'(START_X);
      frog_y    <= 10'(START_Y);
      in_frog   <= 1'b0;
      color     <= '0;
    end else begin
      state     <= state_n;
      facing    <= facing_n;
      dir       <= dir_n;
      frame_cnt <= cnt_n;
      frog_x    <= x_n;
      frog_y    <= y_n;
      in_frog   <= pix_on;
      color     <= pix_on ? rom_color : 6'd0;
    end
  end

`ifdef FROG_HOP_QUEUE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_dir   <= UP;
    end else begin
      q_valid <= q_valid_n;
      q_dir   <= q_dir_n;
    end
  end
`endif

endmodule

// File: tb/tb_frog_hop_gen.sv
// -----------------------------------------------------------------------------
// tb_frog_hop_gen
// Self-checking bench for frog_hop_gen: a behavioural model (painted art maps,
// signed position arithmetic) is compared with the DUT every cycle, and a set
// of directed scenarios pins the model with hand-computed values.
// -----------------------------------------------------------------------------
module tb_frog_hop_gen;

  localparam int FS = 32, STEP = 32, HF = 4, DF = 30;
  localparam int SW = 640, SH = 480, SX = 304, SY = 448;
  localparam int C_GREEN = 12, C_ORANGE = 52, C_WHITE = 63, C_PUPIL = 1, C_RED = 48;

  logic       clk = 1'b0;
  logic       reset, frame_tick, hop_req, kill;
  logic [1:0] hop_dir;
  logic [9:0] colPos, rowPos;
  logic [9:0] frog_x, frog_y;
  logic       busy, dead, in_frog;
  logic [5:0] color;

  frog_hop_gen dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .hop_req    (hop_req),
    .hop_dir    (hop_dir),
    .kill       (kill),
    .colPos     (colPos),
    .rowPos     (rowPos),
    .frog_x     (frog_x),
    .frog_y     (frog_y),
    .busy       (busy),
    .dead       (dead),
    .in_frog    (in_frog),
    .color      (color)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- art maps: 0 extended legs, 1 tucked legs, 2 splat -------
  int art [3][32][32];

  task automatic paint(input int m, input int x0, input int x1,
                       input int y0, input int y1, input int c);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        art[m][y][x] = c;
  endtask

  task automatic build_art();
    for (int m = 0; m < 3; m++)
      for (int y = 0; y < 32; y++)
        for (int x = 0; x < 32; x++)
          art[m][y][x] = 0;
    // Painted back to front.
    paint(0, 0, 7, 20, 29, C_GREEN);  paint(0, 24, 31, 20, 29, C_GREEN);
    paint(1, 2, 7, 20, 25, C_GREEN);  paint(1, 24, 29, 20, 25, C_GREEN);
    for (int m = 0; m < 2; m++) begin
      paint(m, 4, 27, 6, 20, C_GREEN);
      paint(m, 9, 22, 10, 18, C_ORANGE);
      paint(m, 6, 10, 2, 6, C_WHITE);   paint(m, 21, 25, 2, 6, C_WHITE);
      paint(m, 9, 10, 2, 4, C_PUPIL);   paint(m, 21, 22, 2, 4, C_PUPIL);
    end
    paint(2, 2, 7, 20, 25, C_RED);  paint(2, 24, 29, 20, 25, C_RED);
    paint(2, 4, 27, 6, 20, C_RED);
    paint(2, 6, 10, 2, 6, C_WHITE); paint(2, 21, 25, 2, 6, C_WHITE);
  endtask

  // ---------------- behavioural model ---------------------------------------
  int mx, my, mface, mdir, mticks;
  int mmode;           // 0 idle, 1 hopping, 2 splat
  bit mq_v;
  int mq_d;
  bit exp_in;
  int exp_col;
  bit model_valid = 1'b0;

  function automatic int dx(input int d);
    return (d == 2) ? -1 : (d == 3) ? 1 : 0;
  endfunction
  function automatic int dy(input int d);
    return (d == 0) ? -1 : (d == 1) ? 1 : 0;
  endfunction

  task automatic try_hop(input int d);
    int tx, ty;
    mface = d;
    tx = mx + dx(d) * STEP;
    ty = my + dy(d) * STEP;
    if (tx >= 0 && tx <= SW - FS && ty >= 0 && ty <= SH - FS) begin
      mmode  = 1;
      mdir   = d;
      mticks = 0;
    end
  endtask

  task automatic model_step();
    int col, row, lx, ly, ax, ay, m;
    col = int'(colPos);
    row = int'(rowPos);
    exp_in  = 1'b0;
    exp_col = 0;
    if (!reset && col >= mx && col < mx + FS && row >= my && row < my + FS) begin
      lx = (col - mx) * 32 / FS;
      ly = (row - my) * 32 / FS;
      case (mface)
        0:       begin ax = lx;      ay = ly;      end
        1:       begin ax = lx;      ay = 31 - ly; end
        2:       begin ax = ly;      ay = lx;      end
        default: begin ax = 31 - ly; ay = lx;      end
      endcase
      m = (mmode == 2) ? 2 : (mmode == 1 && mticks < HF / 2) ? 0 : 1;
      exp_col = art[m][ay][ax];
      exp_in  = (exp_col != 0);
    end

    if (reset) begin
      mx = SX; my = SY; mface = 0; mdir = 0; mticks = 0; mmode = 0;
      mq_v = 1'b0; mq_d = 0;
      model_valid = 1'b1;
    end else if (kill && mmode != 2) begin
      mmode = 2; mticks = 0; mq_v = 1'b0;
    end else if (mmode == 2) begin
      if (frame_tick) begin
        mticks++;
        if (mticks == DF) begin
          mmode = 0; mx = SX; my = SY; mface = 0;
        end
      end
    end else if (mmode == 1) begin
`ifdef FROG_HOP_QUEUE_EN
      if (hop_req) begin mq_v = 1'b1; mq_d = int'(hop_dir); end
`endif
      if (frame_tick) begin
        mx += dx(mdir) * (STEP / HF);
        my += dy(mdir) * (STEP / HF);
        mticks++;
        if (mticks == HF) begin
          mmode = 0;
`ifdef FROG_HOP_QUEUE_EN
          if (mq_v) begin mq_v = 1'b0; try_hop(mq_d); end
`endif
        end
      end
    end else if (hop_req) begin
      try_hop(int'(hop_dir));
    end
  endtask

  // Compare, then advance the model with the inputs the next edge will see.
  always @(negedge clk) begin
    if (model_valid) begin
      check("frog_x",  int'(frog_x),  mx);
      check("frog_y",  int'(frog_y),  my);
      check("busy",    int'(busy),    int'(mmode != 0));
      check("dead",    int'(dead),    int'(mmode == 2));
      check("in_frog", int'(in_frog), int'(exp_in));
      check("color",   int'(color),   exp_col);
    end
    model_step();
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic cyc(input bit t, input bit r, input int d, input bit k,
                     input int c, input int rw);
    frame_tick = t; hop_req = r; hop_dir = 2'(d); kill = k;
    colPos = 10'(c); rowPos = 10'(rw);
    @(posedge clk); #1;
    frame_tick = 1'b0; hop_req = 1'b0; kill = 1'b0; colPos = '0; rowPos = '0;
  endtask

  task automatic tick();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic hop(input int d);
    cyc(0, 1, d, 0, 0, 0);
    repeat (HF) tick();
  endtask

  // ---------------- directed + random sequence ------------------------------
  initial begin
    build_art();
    reset = 1'b1; frame_tick = 1'b0; hop_req = 1'b0; hop_dir = '0; kill = 1'b0;
    colPos = '0; rowPos = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_x", int'(frog_x), 304);
    check("rst_y", int'(frog_y), 448);
    check("rst_busy", int'(busy), 0);
    check("rst_dead", int'(dead), 0);
    check("rst_in_frog", int'(in_frog), 0);
    check("rst_color", int'(color), 0);
    tick(); tick();
    check("idle_x", int'(frog_x), 304);
    check("idle_y", int'(frog_y), 448);
    check("idle_busy", int'(busy), 0);

    // Down from the bottom row is out of range: dropped, but frog turns.
    cyc(0, 1, 1, 0, 0, 0);
    check("drop_y", int'(frog_y), 448);
    check("drop_busy", int'(busy), 0);
    cyc(0, 0, 0, 0, 313, 476);
    check("down_pupil_in", int'(in_frog), 1);
    check("down_pupil_col", int'(color), C_PUPIL);

    // Up hop with extended-leg pixel, then tucked pose.
    cyc(0, 1, 0, 0, 0, 0);
    check("hop_busy", int'(busy), 1);
    check("hop_y0", int'(frog_y), 448);
    cyc(0, 0, 0, 0, 305, 475);
    check("ext_leg_in", int'(in_frog), 1);
    check("ext_leg_col", int'(color), C_GREEN);
    tick(); check("hop_y1", int'(frog_y), 440);
    tick(); check("hop_y2", int'(frog_y), 432);
    cyc(0, 0, 0, 0, 305, 459);
    check("tuck_leg_in", int'(in_frog), 0);
    tick(); check("hop_y3", int'(frog_y), 424);
    check("hop_busy3", int'(busy), 1);
    tick(); check("hop_y4", int'(frog_y), 416);
    check("hop_done_busy", int'(busy), 0);
    check("hop_x", int'(frog_x), 304);

    // Body pixel and half-open right edge.
    cyc(0, 0, 0, 0, 320, 426);
    check("body_in", int'(in_frog), 1);
    check("body_col", int'(color), C_ORANGE);
    cyc(0, 0, 0, 0, 336, 426);
    check("edge_in", int'(in_frog), 0);
    check("edge_col", int'(color), 0);

    // Kill mid-hop, together with a hop request.
    cyc(0, 1, 0, 0, 0, 0);
    tick(); tick();
    check("pre_kill_y", int'(frog_y), 400);
    cyc(0, 1, 3, 1, 0, 0);
    check("kill_dead", int'(dead), 1);
    check("kill_busy", int'(busy), 1);
    check("kill_x", int'(frog_x), 304);
    cyc(0, 0, 0, 0, 320, 410);
    check("splat_col", int'(color), C_RED);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 2, 0, 0, 0);
    repeat (DF - 1) tick();
    check("dead_hold", int'(dead), 1);
    check("dead_y", int'(frog_y), 400);
    tick();
    check("respawn_dead", int'(dead), 0);
    check("respawn_busy", int'(busy), 0);
    check("respawn_x", int'(frog_x), 304);
    check("respawn_y", int'(frog_y), 448);
    cyc(0, 0, 0, 0, 313, 451);
    check("respawn_face_up", int'(color), C_PUPIL);

    // Request during a hop.
    cyc(0, 1, 0, 0, 0, 0);
    tick();
    cyc(1, 1, 3, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    tick(); tick();
    check("q_hop_y", int'(frog_y), 416);
`ifdef FROG_HOP_QUEUE_EN
    check("q_busy", int'(busy), 1);
    repeat (HF) tick();
    check("q_x", int'(frog_x), 336);
`else
    check("q_busy", int'(busy), 0);
    repeat (HF) tick();
    check("q_x", int'(frog_x), 304);
`endif
    check("q_idle", int'(busy), 0);

    // Climb to the top edge: y=0 is reachable, one more up is dropped.
    repeat (13) hop(0);
    check("top_y", int'(frog_y), 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("top_drop_busy", int'(busy), 0);
    check("top_drop_y", int'(frog_y), 0);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      bit t, r, k;
      int d, c, rw;
      t  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 5) == 0);
      k  = ($urandom_range(0, 80) == 0);
      d  = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        c  = int'(frog_x) + int'($urandom_range(0, 35)) - 2;
        rw = int'(frog_y) + int'($urandom_range(0, 35)) - 2;
        if (c < 0) c = 0;
        if (rw < 0) rw = 0;
      end else begin
        c  = int'($urandom_range(0, 639));
        rw = int'($urandom_range(0, 479));
      end
      if ($urandom_range(0, 999) == 0) reset = 1'b1;
      cyc(t, r, d, k, c, rw);
      reset = 1'b0;
    end

    idle(2);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

endmodule
